ni_route_scheduler: RTL
=======================

NI_ROUTE_SCHEDULER -- requirements
Module: ni_route_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of requesters sharing the routing lookup.
REQ-002 SHALL have parameter ADDR_W, default 32: request address width.
REQ-003 SHALL have parameter PATH_W, default 7: route path width.
REQ-004 SHALL have parameter TGT_W, default 4: transaction target ID width.
REQ-005 SHALL have parameter MAX_OUTST, default 4: maximum in-flight routed transactions, range 1..15.
REQ-006 SHALL have ports: clock input 1, the single clock; reset_n input 1, reset that is synchronous and active-low.
REQ-007 SHALL have ports: req_valid input NREQ, request valid per requester; req_addr input NREQ*ADDR_W, addresses, requester i at bits [i*ADDR_W +: ADDR_W]; req_ready output NREQ, one-hot accept pulse.
REQ-008 SHALL have ports: lut_address output ADDR_W, address driven to the shared routing table; lut_path input PATH_W; lut_target input TGT_W; lut_fail input 1, decode-failure flag.
REQ-009 SHALL have ports: out_valid output 1; out_ready input 1; out_path output PATH_W; out_target output TGT_W; out_id output clog2(NREQ), winning requester; out_err output 1, decode failed.
REQ-010 SHALL have ports: rsp_done input 1, one pulse per completed routed transaction; busy output 1, high when state is not IDLE; err_count output 16, decode-failure count.

Function
REQ-011 SHALL implement FSM IDLE -> LOOKUP -> OUT -> IDLE.
REQ-012 In IDLE, SHALL grant when any req_valid is set and outst_cnt < MAX_OUTST: pulse req_ready[winner] that cycle, register req_addr[winner] into lut_address and the winner into out_id, then go to LOOKUP.
REQ-013 Arbitration SHALL be round-robin: search starts at pointer ptr (reset 0); after a grant to i, ptr = (i+1) mod NREQ.
REQ-014 In LOOKUP, SHALL sample lut_path, lut_target and lut_fail into the out_* registers, set out_valid, and go to OUT.
- Latency: grant in cycle N gives out_valid in cycle N+2.
REQ-015 On failure (lut_fail=1), SHALL force out_path=0 and out_target=0 and set out_err=1.
REQ-016 In OUT, SHALL hold out_valid and all out_* stable until out_ready=1; on that handshake, clear out_valid and return to IDLE.
- No new grant is made in the handshake cycle.
REQ-017 lut_address SHALL stay stable from the grant cycle until the cycle after the OUT handshake.
REQ-018 outst_cnt SHALL increment on an OUT handshake with out_err=0.
- Decrements on rsp_done.
- Simultaneous increment and decrement leaves it unchanged.
- rsp_done at count 0 is ignored (no underflow).
REQ-019 When outst_cnt == MAX_OUTST, no grant SHALL occur; a grant is allowed again the cycle after the count drops.
REQ-020 req_ready SHALL never be high outside IDLE and SHALL never be high for a requester whose req_valid=0.

Reset
REQ-021 While reset_n=0 at a clock edge, SHALL set state=IDLE, ptr=0, outst_cnt=0, and all outputs to 0 (req_ready, lut_address, out_*, busy, err_count).
REQ-022 Reset mid-operation SHALL discard the in-flight lookup with no output handshake.

Configuration
REQ-023 With macro NI_ROUTE_ERR_CNT_EN defined, err_count SHALL increment on each OUT handshake with out_err=1, saturating at 16'hFFFF.
REQ-024 Without NI_ROUTE_ERR_CNT_EN, err_count SHALL be constant 0 and no counter register SHALL be present.

Structure
REQ-025 The FSM state encoding (IDLE=2'd0, LOOKUP=2'd1, OUT=2'd2) and the err_count width constant SHALL live in the shared NI package.
REQ-026 The round-robin arbiter SHALL be a sub-module, ni_rr_arbiter.
- Inputs: request vector, pointer, enable.
- Output: one-hot grant.
- Purely combinational; ptr is held in the parent.

Verification
REQ-027 Reset, then req_valid=2'b01, addr 32'h1A000000, LUT returns path 7'b0000001, target 4'hC: req_ready=2'b01 at N, out_valid at N+2 with path/target as returned, out_id=0, out_err=0.
REQ-028 Both requesters held valid for 4 transactions, out_ready=1, rsp_done pulsed after each: grants alternate 0,1,0,1.
REQ-029 lut_fail=1 for addr 32'h20000000: out_err=1, path 0, target 0; outst_cnt unchanged; err_count=1 with the macro, 0 without.
REQ-030 MAX_OUTST=4, 4 successful routes, no rsp_done: 5th request stalls; rsp_done pulse gives a grant the next cycle; out_ready=0 for 5 cycles keeps out_* stable.
REQ-031 rsp_done coinciding with a successful handshake at count 2: count stays 2. reset_n=0 in LOOKUP: next cycle all outputs 0, no out_valid.

Source files
------------

// File: rtl/ni_route_scheduler_pkg.sv
// Shared types and constants for the NI route scheduler and its round-robin arbiter.
// The NI_ROUTE_ERR_CNT_EN macro (used by the top) enables the decode-failure counter.
package ni_route_scheduler_pkg;

  localparam int unsigned ERR_CNT_W   = 16;
  localparam int unsigned OUTST_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_OUT    = 2'd2
  } ni_state_e;

  // Round-robin pointer advance: the requester after the winner, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/ni_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active request
// at or after i_ptr. The pointer itself is held by the parent.
module ni_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    if (i_en) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        w_idx = int'(32'(i_ptr)) + k;
        if (w_idx >= int'(NREQ)) begin
          w_idx = w_idx - int'(NREQ);
        end
        for (int j = 0; j < int'(NREQ); j++) begin
          if (!w_found && (j == w_idx) && i_req[j]) begin
            o_grant[j] = 1'b1;
            w_found    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ni_route_scheduler.sv
// Shares one routing lookup table among NREQ requesters and bounds in-flight routes.
// Define NI_ROUTE_ERR_CNT_EN to build the saturating decode-failure counter on err_count.
module ni_route_scheduler
  import ni_route_scheduler_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PATH_W    = 7,
  parameter int unsigned TGT_W     = 4,
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]      lut_address,
  input  logic [PATH_W-1:0]      lut_path,
  input  logic [TGT_W-1:0]       lut_target,
  input  logic                   lut_fail,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PATH_W-1:0]      out_path,
  output logic [TGT_W-1:0]       out_target,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_err,
  input  logic                   rsp_done,
  output logic                   busy,
  output logic [ERR_CNT_W-1:0]   err_count
);

  ni_state_e              r_state;
  logic [ID_W-1:0]        r_ptr;
  logic [OUTST_CNT_W-1:0] r_outst_cnt;
  logic [ADDR_W-1:0]      r_lut_address;
  logic                   r_out_valid;
  logic [PATH_W-1:0]      r_out_path;
  logic [TGT_W-1:0]       r_out_target;
  logic [ID_W-1:0]        r_out_id;
  logic                   r_out_err;

  logic                   w_grant_en;
  logic [NREQ-1:0]        w_grant;
  logic                   w_grant_any;
  logic [ID_W-1:0]        w_win_id;
  logic [ADDR_W-1:0]      w_win_addr;
  logic                   w_hs;
  logic                   w_inc;
  logic                   w_dec;

  // Reset gating keeps req_ready low while reset_n is asserted.
  assign w_grant_en = reset_n && (r_state == ST_IDLE) &&
                      (r_outst_cnt < OUTST_CNT_W'(MAX_OUTST));

  ni_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_grant_en),
    .o_grant (w_grant)
  );

  assign w_grant_any = |w_grant;

  always_comb begin
    w_win_id   = '0;
    w_win_addr = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_grant[i]) begin
        w_win_id   = ID_W'(i);
        w_win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_hs  = (r_state == ST_OUT) && out_ready;
  assign w_inc = w_hs && !r_out_err;
  assign w_dec = rsp_done && (r_outst_cnt != '0);

  // Lookup sequencing, round-robin pointer and in-flight route count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_outst_cnt   <= '0;
      r_lut_address <= '0;
      r_out_valid   <= 1'b0;
      r_out_path    <= '0;
      r_out_target  <= '0;
      r_out_id      <= '0;
      r_out_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_lut_address <= w_win_addr;
            r_out_id      <= w_win_id;
            r_ptr         <= ID_W'(rr_next(32'(w_win_id), NREQ));
            r_state       <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          r_out_valid  <= 1'b1;
          r_out_err    <= lut_fail;
          r_out_path   <= lut_fail ? '0 : lut_path;
          r_out_target <= lut_fail ? '0 : lut_target;
          r_state      <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      case ({w_inc, w_dec})
        2'b10:   r_outst_cnt <= r_outst_cnt + OUTST_CNT_W'(1);
        2'b01:   r_outst_cnt <= r_outst_cnt - OUTST_CNT_W'(1);
        default: r_outst_cnt <= r_outst_cnt;
      endcase
    end
  end

`ifdef NI_ROUTE_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_count;

  // Saturating count of routes delivered with a decode failure.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_err_count <= '0;
    end else if (w_hs && r_out_err && (r_err_count != {ERR_CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

  assign req_ready   = w_grant;
  assign lut_address = r_lut_address;
  assign out_valid   = r_out_valid;
  assign out_path    = r_out_path;
  assign out_target  = r_out_target;
  assign out_id      = r_out_id;
  assign out_err     = r_out_err;
  assign busy        = (r_state != ST_IDLE);

endmodule
